// File: rtl/ssd1306_fb_streamer_if.sv
// Handshake bundle between the frame streamer, the framebuffer RAM, the SPI
// master and the controlling logic. The streamer owns the master modport.
interface ssd1306_fb_streamer_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  init_done;
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [7:0]            fb_data;
  logic [7:0]            spi_data;
  logic                  spi_wr;
  logic                  spi_done;
  logic                  oled_dc;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  init_done, start, abort, fb_data, spi_done,
    output fb_addr, spi_data, spi_wr, oled_dc, busy, frame_done
  );

  modport slave (
    output init_done, start, abort, fb_data, spi_done,
    input  fb_addr, spi_data, spi_wr, oled_dc, busy, frame_done
  );
endinterface

// File: rtl/ssd1306_fb_streamer.sv
// Streams one SSD1306 frame: a 6-byte page/column addressing header followed
// by COLS*PAGES framebuffer bytes, one byte per SPI master transaction.
module ssd1306_fb_streamer #(
  parameter int COLS       = 128,
  parameter int PAGES      = 4,
  parameter int ADDR_WIDTH = 9   // COLS*PAGES must fit in 2**ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ssd1306_fb_streamer_if.master   bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(COLS*PAGES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_WR, CMD_WAIT, RD_ADDR, RD_LATCH, DATA_WR, DATA_WAIT, DONE
  } state_t;

  state_t                state;
  logic [2:0]            hdr_idx;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [7:0]            spi_data;
  logic                  spi_wr;
  logic                  oled_dc;
  logic                  busy;
  logic                  frame_done;

  // Page range 0..PAGES-1, then column range 0..COLS-1.
  function automatic logic [7:0] hdr_byte(input logic [2:0] i);
    case (i)
      3'd0:    hdr_byte = 8'h22;
      3'd2:    hdr_byte = 8'(PAGES - 1);
      3'd3:    hdr_byte = 8'h21;
      3'd5:    hdr_byte = 8'(COLS - 1);
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hdr_idx    <= '0;
      idx        <= '0;
      fb_addr    <= '0;
      spi_data   <= 8'h00;
      spi_wr     <= 1'b0;
      oled_dc    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      spi_wr     <= 1'b0;
      frame_done <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        idx     <= '0;
        hdr_idx <= '0;
      end else begin
        case (state)
          IDLE: if (bus.start && bus.init_done) begin
            state    <= CMD_WR;
            busy     <= 1'b1;
            hdr_idx  <= '0;
            spi_data <= hdr_byte(3'd0);
            oled_dc  <= 1'b0;
            spi_wr   <= 1'b1;
          end
          CMD_WR: state <= CMD_WAIT;
          CMD_WAIT: if (bus.spi_done) begin
            if (hdr_idx == 3'd5) begin
              state   <= RD_ADDR;
              fb_addr <= idx;
            end else begin
              hdr_idx  <= hdr_idx + 3'd1;
              spi_data <= hdr_byte(hdr_idx + 3'd1);
              spi_wr   <= 1'b1;
              state    <= CMD_WR;
            end
          end
          RD_ADDR: state <= RD_LATCH;
          // RAM output is valid here, one cycle after fb_addr was presented.
          RD_LATCH: begin
            spi_data <= bus.fb_data;
            oled_dc  <= 1'b1;
            spi_wr   <= 1'b1;
            state    <= DATA_WR;
          end
          DATA_WR: state <= DATA_WAIT;
          DATA_WAIT: if (bus.spi_done) begin
            if (idx == LAST_IDX) begin
              idx        <= '0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx     <= idx + 1'b1;
              fb_addr <= idx + 1'b1;
              state   <= RD_ADDR;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.fb_addr    = fb_addr;
  assign bus.spi_data   = spi_data;
  assign bus.spi_wr     = spi_wr;
  assign bus.oled_dc    = oled_dc;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_ssd1306_fb_streamer.sv
// Bench: default-size streamer against a cycle-level frame model, plus a
// PAGES=8 instance checked at the byte-stream level.
module tb_ssd1306_fb_streamer;
  localparam int TOT1 = 6 + 512;
  localparam int TOT2 = 6 + 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ssd1306_fb_streamer_if #(.ADDR_WIDTH(9))  b1 ();
  ssd1306_fb_streamer_if #(.ADDR_WIDTH(10)) b2 ();

  ssd1306_fb_streamer #(.COLS(128), .PAGES(4), .ADDR_WIDTH(9))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ssd1306_fb_streamer #(.COLS(128), .PAGES(8), .ADDR_WIDTH(10))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    b1.fb_data <= ram[b1.fb_addr];
    b2.fb_data <= ram[b2.fb_addr];
  end

  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame content: header for a 128-column display, then RAM in address order.
  function automatic logic [7:0] exp_byte(input int p, input int pages);
    if (p < 6) begin
      case (p)
        0:       return 8'h22;
        2:       return 8'(pages - 1);
        3:       return 8'h21;
        5:       return 8'h7F;
        default: return 8'h00;
      endcase
    end
    return ram[10'(p - 6)];
  endfunction

  // SPI master stand-in for dut1: spi_done spi_delay cycles after spi_wr,
  // optionally with stray spi_done pulses while no byte is in flight.
  int spi_delay = 20;
  bit spur_en = 1'b0;
  int cd = 0;
  initial begin
    b1.spi_done = 1'b0;
    forever begin
      @(negedge clk);
      if (b1.spi_wr === 1'b1) cd = spi_delay;
      @(posedge clk); #1;
      b1.spi_done = 1'b0;
      if (!rst_n) cd = 0;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) b1.spi_done = 1'b1;
      end else if (spur_en && $urandom_range(0, 7) == 0) b1.spi_done = 1'b1;
    end
  end

  // dut2 SPI stand-in: done two cycles after each write.
  logic [1:0] sh2;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) sh2 <= '0;
    else        sh2 <= {sh2[0], b2.spi_wr};
  assign b2.spi_done = sh2[1];

  logic [8:0] q2 [$];
  int n_fd2 = 0;
  always @(negedge clk) begin
    if (b2.spi_wr === 1'b1) q2.push_back({b2.oled_dc, b2.spi_data});
    if (b2.frame_done === 1'b1) n_fd2++;
  end

  // Cycle-level model of dut1: a frame is a byte position 0..TOT1-1; the next
  // write is due 1 cycle after a header done, 3 after any done leading to data.
  int cyc = 0, wr_at = -1, pos = 0, n_wr1 = 0, n_fd1 = 0;
  bit m_busy = 1'b0, m_fd = 1'b0, outst = 1'b0, m_wr;
  logic [8:0] q1 [$];
  always @(negedge clk) begin
    cyc++;
    if (b1.spi_wr === 1'b1) begin
      n_wr1++;
      q1.push_back({b1.oled_dc, b1.spi_data});
    end
    if (b1.frame_done === 1'b1) n_fd1++;
    if (!rst_n) begin
      chk("reset spi_wr", 32'(b1.spi_wr), 0);
      chk("reset busy", 32'(b1.busy), 0);
      chk("reset frame_done", 32'(b1.frame_done), 0);
      chk("reset spi_data", 32'(b1.spi_data), 0);
      chk("reset oled_dc", 32'(b1.oled_dc), 0);
      chk("reset fb_addr", 32'(b1.fb_addr), 0);
      m_busy = 1'b0; m_fd = 1'b0; outst = 1'b0; wr_at = -1;
    end else begin
      m_wr = (cyc == wr_at);
      chk("busy", 32'(b1.busy), 32'(m_busy));
      chk("spi_wr", 32'(b1.spi_wr), 32'(m_wr));
      chk("frame_done", 32'(b1.frame_done), 32'(m_fd));
      if (m_wr || outst) begin
        chk("spi_data", 32'(b1.spi_data), 32'(exp_byte(pos, 4)));
        chk("oled_dc", 32'(b1.oled_dc), 32'(pos >= 6));
      end
      if (m_busy && pos >= 6) chk("fb_addr", 32'(b1.fb_addr), 32'(pos - 6));
      if (!m_busy) begin
        if (b1.start === 1'b1 && b1.init_done === 1'b1) begin
          m_busy = 1'b1; pos = 0; wr_at = cyc + 1;
        end
      end else if (b1.abort === 1'b1) begin
        m_busy = 1'b0; m_fd = 1'b0; outst = 1'b0; wr_at = -1;
      end else if (m_fd) begin
        m_busy = 1'b0; m_fd = 1'b0;
      end else if (m_wr) begin
        outst = 1'b1;
      end else if (outst && b1.spi_done === 1'b1) begin
        outst = 1'b0;
        if (pos == TOT1 - 1) m_fd = 1'b1;
        else begin
          pos++;
          wr_at = cyc + ((pos <= 5) ? 1 : 3);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    b1.start = 1'b1; tick(); b1.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (b1.busy === 1'b1 && n < limit) begin tick(); n++; end
    chk(name, 32'(n < limit), 1);
  endtask

  task automatic check_frame(input string name, input int base);
    chk({name, " byte count"}, 32'(q1.size() - base), TOT1);
    for (int k = 0; k < TOT1; k++)
      if (base + k < q1.size())
        chk(name, 32'(q1[base + k]), 32'({1'(k >= 6), exp_byte(k, 4)}));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, wbase, fd0, n;
    foreach (ram[i]) ram[i] = 8'($urandom);
    rst_n = 1'b1;
    b1.start = 1'b0; b1.abort = 1'b0; b1.init_done = 1'b0;
    b2.start = 1'b0; b2.abort = 1'b0; b2.init_done = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("dut2 reset fb_addr", 32'(b2.fb_addr), 0);
    chk("dut2 reset spi_wr", 32'(b2.spi_wr), 0);
    rst_n = 1'b1;
    tick();

    // Full frame on both sizes, slow SPI for dut1.
    b1.init_done = 1'b1; spi_delay = 20;
    base = q1.size(); fd0 = n_fd1;
    b1.start = 1'b1; b2.start = 1'b1; tick(); b1.start = 1'b0; b2.start = 1'b0;
    wait_idle("frame1 completes", 20000);
    repeat (2) tick();
    chk("hdr0", 32'(q1[base + 0]), 32'h022);
    chk("hdr1", 32'(q1[base + 1]), 32'h000);
    chk("hdr2", 32'(q1[base + 2]), 32'h003);
    chk("hdr3", 32'(q1[base + 3]), 32'h021);
    chk("hdr4", 32'(q1[base + 4]), 32'h000);
    chk("hdr5", 32'(q1[base + 5]), 32'h07F);
    chk("data0", 32'(q1[base + 6]), 32'({1'b1, ram[0]}));
    check_frame("frame1", base);
    chk("frame1 frame_done count", 32'(n_fd1 - fd0), 1);
    chk("frame1 final fb_addr", 32'(b1.fb_addr), 511);
    chk("dut2 idle", 32'(b2.busy), 0);
    chk("dut2 byte count", 32'(q2.size()), TOT2);
    chk("dut2 hdr2", 32'(q2[2]), 32'h007);
    chk("dut2 hdr5", 32'(q2[5]), 32'h07F);
    for (int k = 0; k < TOT2; k++)
      if (k < q2.size()) chk("dut2 frame", 32'(q2[k]), 32'({1'(k >= 6), exp_byte(k, 8)}));
    chk("dut2 frame_done count", 32'(n_fd2), 1);
    chk("dut2 final fb_addr", 32'(b2.fb_addr), 1023);

    // Start without init_done is ignored; start while busy is ignored.
    wbase = n_wr1; fd0 = n_fd1;
    b1.init_done = 1'b0; pulse_start(); repeat (10) tick();
    chk("no start without init_done busy", 32'(b1.busy), 0);
    chk("no start without init_done wr", 32'(n_wr1 - wbase), 0);
    b1.init_done = 1'b1; spi_delay = $urandom_range(1, 4);
    base = q1.size();
    pulse_start(); repeat (50) tick(); pulse_start();
    wait_idle("frame2 completes", 20000);
    repeat (2) tick();
    chk("frame2 spi_wr total", 32'(n_wr1 - wbase), 518);
    chk("frame2 frame_done count", 32'(n_fd1 - fd0), 1);
    check_frame("frame2", base);

    // Immediate spi_done: back-to-back throughput.
    spi_delay = 1; base = q1.size();
    pulse_start();
    n = 0;
    while (b1.busy === 1'b1 && n < 5000) begin n++; tick(); end
    chk("fast frame busy cycles", 32'(n), 2061);
    repeat (2) tick();
    check_frame("frame3", base);

    // Abort while data byte 100 is in flight.
    spi_delay = 4; wbase = n_wr1; fd0 = n_fd1;
    pulse_start();
    n = 0;
    while (n_wr1 - wbase < 107 && n < 5000) begin tick(); n++; end
    chk("reached data byte 100", 32'(n < 5000), 1);
    b1.abort = 1'b1; tick(); b1.abort = 1'b0;
    chk("abort busy low", 32'(b1.busy), 0);
    chk("abort spi_wr low", 32'(b1.spi_wr), 0);
    repeat (30) tick();
    chk("abort no frame_done", 32'(n_fd1 - fd0), 0);
    base = q1.size();
    pulse_start();
    wait_idle("frame after abort", 20000);
    repeat (2) tick();
    chk("restart header first", 32'(q1[base]), 32'h022);
    check_frame("frame4", base);

    // Reset during CMD_WAIT.
    spi_delay = 20; wbase = n_wr1;
    pulse_start();
    n = 0;
    while (n_wr1 == wbase && n < 100) begin tick(); n++; end
    repeat (5) tick();
    rst_n = 1'b0; tick();
    chk("mid-frame reset busy", 32'(b1.busy), 0);
    chk("mid-frame reset spi_data", 32'(b1.spi_data), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("no spi_wr after reset", 32'(n_wr1 - wbase), 1);
    spi_delay = 3; base = q1.size();
    pulse_start();
    wait_idle("frame after reset", 20000);
    repeat (2) tick();
    check_frame("frame5", base);

    // Random traffic: stray starts, stray spi_done, init_done drops, aborts.
    spur_en = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      b1.init_done = ($urandom_range(0, 15) != 0);
      b1.start     = ($urandom_range(0, 149) == 0);
      b1.abort     = ($urandom_range(0, 3999) == 0);
      if ($urandom_range(0, 499) == 0) spi_delay = $urandom_range(1, 6);
      tick();
    end
    b1.start = 1'b0; b1.abort = 1'b0; b1.init_done = 1'b1; spur_en = 1'b0;
    wait_idle("random phase drains", 40000);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ssd1306_fb_streamer.md
SSD1306_FB_STREAMER -- requirements
Module: ssd1306_fb_streamer

Interface
REQ-001 SHALL have parameter COLS, default 128, meaning display columns per page.
REQ-002 SHALL have parameter PAGES, default 4, meaning 8-row pages per frame.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, meaning framebuffer address width; COLS*PAGES SHALL NOT exceed 2**ADDR_WIDTH.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge system clock (same clock as the SPI master).
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 init_done  input  1  high once the OLED init sequencer has completed.
REQ-008 start  input  1  single-cycle request to send one full frame.
REQ-009 abort  input  1  synchronous request to cancel the current frame.
REQ-010 fb_addr  output  ADDR_WIDTH  framebuffer read address; synchronous RAM, data valid one cycle after the address is driven.
REQ-011 fb_data  input  8  framebuffer read data (one page column byte, LSB = top row).
REQ-012 spi_data  output  8  byte to the SPI master data_in.
REQ-013 spi_wr  output  1  one-cycle pulse loading spi_data into the SPI master.
REQ-014 spi_done  input  1  one-cycle pulse from the SPI master (charreceived) when a byte has finished shifting.
REQ-015 oled_dc  output  1  0 = command byte, 1 = display data byte.
REQ-016 busy  output  1  high from frame acceptance until return to IDLE.
REQ-017 frame_done  output  1  one-cycle pulse after the last data byte's spi_done.

Function
REQ-018 States SHALL be IDLE, CMD_WR, CMD_WAIT, RD_ADDR, RD_LATCH, DATA_WR, DATA_WAIT, DONE.
REQ-019 In IDLE, start=1 with init_done=1 SHALL move to CMD_WR next cycle; start with init_done=0 SHALL be ignored.
REQ-020 start while busy=1 SHALL be ignored (no queueing).
REQ-021 Command header SHALL be the six bytes 0x22, 0x00, PAGES-1, 0x21, 0x00, COLS-1 in that order, oled_dc=0.
REQ-022 CMD_WR SHALL assert spi_wr for exactly one cycle with spi_data = current header byte, then enter CMD_WAIT.
REQ-023 In CMD_WAIT, spi_done SHALL advance to CMD_WR of the next header byte on the following cycle (1-cycle gap); after the sixth byte, to RD_ADDR.
REQ-024 Data SHALL be COLS*PAGES bytes, index 0..COLS*PAGES-1, fb_addr = index (page-major, column-minor), oled_dc=1.
REQ-025 Data pipeline: RD_ADDR drives fb_addr; RD_LATCH registers fb_data into spi_data; DATA_WR pulses spi_wr; i.e. spi_wr occurs 3 cycles after the preceding spi_done.
REQ-026 In DATA_WAIT, spi_done SHALL increment the index and go to RD_ADDR, or go to DONE after the last index.
REQ-027 DONE SHALL pulse frame_done for one cycle, clear busy, and return to IDLE the next cycle.
REQ-028 oled_dc SHALL change only in the cycle before a spi_wr pulse and remain stable until that byte's spi_done.
REQ-029 spi_data SHALL remain stable from spi_wr until the matching spi_done.
REQ-030 spi_done outside CMD_WAIT/DATA_WAIT SHALL be ignored.
REQ-031 abort=1 in any non-IDLE state SHALL return to IDLE next cycle, spi_wr=0, busy=0, no frame_done; the next frame restarts from the header.
REQ-032 Index counter SHALL wrap to 0 when a frame completes or aborts; it SHALL NOT exceed COLS*PAGES-1.
REQ-033 busy SHALL rise the cycle after start is accepted and fall in the cycle after DONE.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, spi_wr=0, spi_data=0x00, oled_dc=0, fb_addr=0, busy=0, frame_done=0, index=0.
REQ-035 Reset mid-frame SHALL discard the frame; after release, no spi_wr until a new accepted start.

Verification
REQ-036 Full frame, defaults, SPI model returning spi_done 20 cycles after each spi_wr -> bytes 22,00,03,21,00,7F with dc=0, then 512 bytes equal to RAM[0..511] with dc=1, one frame_done.
REQ-037 start with init_done=0, then start while busy -> no spi_wr for the first; second start ignored, exactly 518 spi_wr pulses total.
REQ-038 spi_done returned in the cycle immediately after spi_wr -> command spacing 1 idle cycle, data spacing exactly 3 cycles from spi_done to spi_wr, no byte lost.
REQ-039 abort during data byte 100 -> busy=0 next cycle, no frame_done; a new start re-sends header 0x22 first.
REQ-040 rst_n low during CMD_WAIT, then release and start -> all outputs at reset values while low, frame restarts cleanly.
REQ-041 COLS=128, PAGES=8, ADDR_WIDTH=10 -> header 22,00,07,21,00,7F, 1024 data bytes, fb_addr final value 1023.
